// File: rtl/t09_mode_pkg.sv
// t09_mode_pkg: shared definitions for the mode controller.
//   - mode encodings MODE_0..MODE_2 (encoding 3 is illegal)
//   - FSM state enum state_t
//   - next_mode(): mode successor used when a change is proposed
package t09_mode_pkg;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    WAIT_IDLE,
    REQ,
    RELEASE
  } state_t;

  // Cycle 0 -> 1 -> 2 -> 0; the illegal encoding recovers to MODE_1.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_0:  return MODE_1;
      MODE_1:  return MODE_2;
      MODE_2:  return MODE_0;
      default: return MODE_1;
    endcase
  endfunction

endpackage

// File: rtl/t09_btn_sync.sv
// t09_btn_sync: 2-flop synchronizer for the raw mode-select button.
// Ports:
//   clk     - sampling clock
//   nrst    - asynchronous active-low reset, clears both flops
//   i_btn   - raw button, asynchronous to clk
//   o_btn_s - synchronized button level (2 clk latency)
module t09_btn_sync (
  input  logic clk,
  input  logic nrst,
  input  logic i_btn,
  output logic o_btn_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  assign o_btn_s = r_sync;

endmodule

// File: rtl/t09_mode_ctrl.sv
// t09_mode_ctrl: debounced button-driven mode selector with a
// request/ack handshake towards a downstream datapath.
// Ports:
//   clk          - clock, rising edge
//   nrst         - asynchronous active-low reset
//   btn          - raw mode-select button (asynchronous, active-high)
//   busy         - downstream busy; no request is raised while high
//   ack          - downstream accepts pending_mode (only looked at in REQ)
//   err_clr      - pulse clearing the sticky err flag
//   mode         - committed mode
//   pending_mode - proposed mode, valid while mode_req=1
//   mode_req     - change request
//   mode_stb     - one-cycle pulse while the newly committed mode is first visible
//   err          - sticky ack-timeout flag
module t09_mode_ctrl
  import t09_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn,
  input  logic       busy,
  input  logic       ack,
  input  logic       err_clr,
  output logic [1:0] mode,
  output logic [1:0] pending_mode,
  output logic       mode_req,
  output logic       mode_stb,
  output logic       err
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  logic       w_btn_s;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_mode;
  logic [1:0] r_pending;
  logic       r_req;
  logic       r_stb;
  logic       r_err;

  t09_btn_sync u_sync (
    .clk     (clk),
    .nrst    (nrst),
    .i_btn   (btn),
    .o_btn_s (w_btn_s)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mode    <= MODE_1;
      r_pending <= MODE_2;
      r_req     <= 1'b0;
      r_stb     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      // Clear first so that a timeout in the same cycle overrides it below.
      if (err_clr) r_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_btn_s) begin
            r_state <= PRESS;
            r_cnt   <= '0;
          end
        end

        PRESS: begin
          if (!w_btn_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= WAIT_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        WAIT_IDLE: begin
          if (!busy) begin
            r_state   <= REQ;
            r_cnt     <= '0;
            r_pending <= next_mode(r_mode);
            r_req     <= 1'b1;
          end
        end

        REQ: begin
          // ack is tested before the timeout so a last-cycle ack still commits.
          if (ack) begin
            r_mode  <= r_pending;
            r_stb   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= RELEASE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= RELEASE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        RELEASE: begin
          // Any high sample restarts the release debounce, so a held
          // button can never produce a second request.
          if (w_btn_s) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mode         = r_mode;
  assign pending_mode = r_pending;
  assign mode_req     = r_req;
  assign mode_stb     = r_stb;
  assign err          = r_err;

endmodule

// File: tb/tb_t09_mode_ctrl.sv
// tb_t09_mode_ctrl: self-checking bench for t09_mode_ctrl with
// DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=8. Expected behaviour is taken
// from a transaction-level model: current mode, a successor table,
// and latencies computed from the debounce/timeout figures.
module tb_t09_mode_ctrl;

  localparam int DEB      = 4;
  localparam int TO       = 8;
  localparam int SYNC_LAT = 2;
  // Raw btn edge to observed mode_req rise (busy low).
  localparam int REQ_LAT  = SYNC_LAT + DEB + 2;
  // Low time that safely returns the block to IDLE after a press.
  localparam int REL_WAIT = SYNC_LAT + DEB + 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       btn;
  logic       busy;
  logic       ack;
  logic       err_clr;
  logic [1:0] mode;
  logic [1:0] pending_mode;
  logic       mode_req;
  logic       mode_stb;
  logic       err;

  int checks = 0;
  int errors = 0;

  int exp_mode;
  bit exp_err;
  int succ_tbl [4] = '{1, 2, 0, 1};

  t09_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .btn          (btn),
    .busy         (busy),
    .ack          (ack),
    .err_clr      (err_clr),
    .mode         (mode),
    .pending_mode (pending_mode),
    .mode_req     (mode_req),
    .mode_stb     (mode_stb),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs are driven and outputs sampled just after the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // One full press: wait for the request, answer it (or let it time out),
  // then keep the button held for hold_extra cycles. Button stays high.
  task automatic run_press(input int ack_dly, input int busy_cyc,
                           input int hold_extra, input bit clr_at_to);
    int exp_next;
    int lat_exp;
    int bad;
    exp_next = succ_tbl[exp_mode];
    lat_exp  = REQ_LAT + busy_cyc;
    bad      = 0;
    busy     = (busy_cyc > 0);
    btn      = 1'b1;
    for (int k = 1; k <= lat_exp; k++) begin
      tick();
      if (k < lat_exp && (mode_req !== 1'b0 || mode_stb !== 1'b0)) bad++;
      if (k == lat_exp - 1) busy = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL req_early: %0d cycles with request/strobe high, required 0", bad);
    end
    checks++;
    if (mode_req !== 1'b1) begin
      errors++;
      $display("FAIL req_latency: mode_req=%b after %0d cycles, required 1", mode_req, lat_exp);
    end
    checks++;
    if (pending_mode !== 2'(exp_next)) begin
      errors++;
      $display("FAIL pending_mode: got %0d required %0d", pending_mode, exp_next);
    end

    bad = 0;
    if (ack_dly < TO) begin
      for (int k = 0; k < ack_dly; k++) begin
        busy = 1'($urandom);
        tick();
        if (mode_req !== 1'b1 || mode !== 2'(exp_mode) || mode_stb !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL req_hold: %0d bad cycles while awaiting ack, required 0", bad);
      end
      ack = 1'b1;
      tick();
      ack  = 1'b0;
      busy = 1'b0;
      checks++;
      if (mode !== 2'(exp_next) || mode_stb !== 1'b1 || mode_req !== 1'b0 || err !== exp_err) begin
        errors++;
        $display("FAIL commit: mode=%0d stb=%b req=%b err=%b, required mode=%0d stb=1 req=0 err=%b",
                 mode, mode_stb, mode_req, err, exp_next, exp_err);
      end
      exp_mode = exp_next;
      tick();
      checks++;
      if (mode_stb !== 1'b0) begin
        errors++;
        $display("FAIL stb_width: mode_stb=%b one cycle after commit, required 0", mode_stb);
      end
    end else begin
      for (int k = 1; k < TO; k++) begin
        busy = 1'($urandom);
        tick();
        if (mode_req !== 1'b1 || mode_stb !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL timeout_hold: %0d bad cycles in the %0d-cycle request window, required 0", bad, TO);
      end
      err_clr = clr_at_to;
      tick();
      err_clr = 1'b0;
      busy    = 1'b0;
      checks++;
      if (mode_req !== 1'b0 || err !== 1'b1 || mode !== 2'(exp_mode) || mode_stb !== 1'b0) begin
        errors++;
        $display("FAIL timeout: req=%b err=%b mode=%0d stb=%b, required req=0 err=1 mode=%0d stb=0",
                 mode_req, err, mode, mode_stb, exp_mode);
      end
      exp_err = 1'b1;
    end

    bad = 0;
    for (int k = 0; k < hold_extra; k++) begin
      tick();
      if (mode_req !== 1'b0 || mode_stb !== 1'b0 || mode !== 2'(exp_mode)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_single: %0d cycles with extra activity while held, required 0", bad);
    end
  endtask

  task automatic release_btn();
    int bad;
    bad = 0;
    btn = 1'b0;
    for (int k = 0; k < REL_WAIT; k++) begin
      tick();
      if (mode_req !== 1'b0 || mode_stb !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL release_quiet: %0d active cycles during release, required 0", bad);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: err=%b after clear pulse, required 0", err);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; btn = 1'b0; busy = 1'b0; ack = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (mode !== 2'd1 || pending_mode !== 2'd2 || mode_req !== 1'b0 ||
        mode_stb !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: mode=%0d pend=%0d req=%b stb=%b err=%b, required 1 2 0 0 0",
               mode, pending_mode, mode_req, mode_stb, err);
    end
    nrst = 1'b1;
    repeat (2) tick();
    exp_mode = 1;
    exp_err  = 1'b0;
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 3; i++) begin
      run_press(2, 0, 0, 1'b0);
      release_btn();
    end
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL clean_cycle: mode=%0d after three presses, required 1", mode);
    end
  endtask

  task automatic test_bounce();
    int bad;
    for (int i = 0; i < 4; i++) begin
      bad = 0;
      btn = 1'b1;
      repeat (3) begin tick(); ack = 1'($urandom); if (mode_req !== 1'b0) bad++; end
      btn = 1'b0;
      repeat ($urandom_range(1, 3)) begin tick(); if (mode_req !== 1'b0) bad++; end
      btn = 1'b1;
      repeat (3) begin tick(); ack = 1'($urandom); if (mode_req !== 1'b0) bad++; end
      btn = 1'b0;
      ack = 1'b0;
      repeat (12) begin tick(); if (mode_req !== 1'b0 || mode !== 2'(exp_mode)) bad++; end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL bounce: %0d cycles with request or mode change, required 0", bad);
      end
    end
  endtask

  task automatic test_held();
    int bad;
    run_press(2, 0, 90, 1'b0);
    bad = 0;
    repeat (3) begin
      btn = 1'b0;
      repeat ($urandom_range(1, DEB - 1)) begin
        ack = 1'($urandom); tick();
        if (mode_req !== 1'b0 || mode_stb !== 1'b0 || mode !== 2'(exp_mode)) bad++;
      end
      btn = 1'b1;
      repeat (12) begin
        ack = 1'($urandom); tick();
        if (mode_req !== 1'b0 || mode_stb !== 1'b0 || mode !== 2'(exp_mode)) bad++;
      end
    end
    ack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL short_release: %0d active cycles after short releases, required 0", bad);
    end
    release_btn();
    run_press(1, 0, 0, 1'b0);
    release_btn();
  endtask

  task automatic test_reset_midop();
    btn = 1'b1;
    repeat (REQ_LAT) tick();
    checks++;
    if (mode_req !== 1'b1) begin
      errors++;
      $display("FAIL midop_req: mode_req=%b before reset, required 1", mode_req);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (mode !== 2'd1 || pending_mode !== 2'd2 || mode_req !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: mode=%0d pend=%0d req=%b err=%b, required 1 2 0 0",
               mode, pending_mode, mode_req, err);
    end
    btn = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    exp_mode = 1;
    exp_err  = 1'b0;
    run_press(0, 0, 0, 1'b0);
    release_btn();
  endtask

  task automatic test_busy();
    run_press(2, 20 + int'($urandom_range(0, 5)), 0, 1'b0);
    release_btn();
  endtask

  task automatic test_timeout();
    run_press(TO + 3, 0, 0, 1'b0);
    release_btn();
    pulse_err_clr();
    run_press(TO + 3, 0, 0, 1'b1);
    release_btn();
    pulse_err_clr();
    run_press(TO - 1, 0, 0, 1'b0);
    release_btn();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL last_cycle_ack: err=%b, required 0", err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_press(int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 10)), 1'($urandom));
      release_btn();
      if ($urandom_range(0, 1) == 1) pulse_err_clr();
      checks++;
      if (mode !== 2'(exp_mode) || err !== exp_err) begin
        errors++;
        $display("FAIL random_state: mode=%0d err=%b, required mode=%0d err=%b",
                 mode, err, exp_mode, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_held();
    test_reset_midop();
    test_busy();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t09_mode_ctrl.md
T09_MODE_CTRL -- requirements
Module: t09_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16; consecutive synchronized cycles a button level must hold to be accepted, both press and release; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 255; REQ-state cycles allowed without ack before abort; legal range 1..255.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port nrst  input  1  reset, asynchronous, active-low.
REQ-005 Port btn  input  1  raw mode-select button, asynchronous to clk, active-high.
REQ-006 Port busy  input  1  downstream datapath busy; a mode change shall not be requested while high.
REQ-007 Port ack  input  1  downstream accepts the requested mode; sampled only in REQ.
REQ-008 Port err_clr  input  1  single-cycle pulse that clears err.
REQ-009 Port mode  output  2  committed mode, registered.
REQ-010 Port pending_mode  output  2  proposed next mode, registered, valid while mode_req=1.
REQ-011 Port mode_req  output  1  change request to downstream, registered.
REQ-012 Port mode_stb  output  1  one-cycle pulse in the cycle after mode changes.
REQ-013 Port err  output  1  sticky ack-timeout flag.

Function
REQ-014 btn shall pass through a 2-flop synchronizer to give btn_s; all logic shall use only btn_s.
REQ-015 Mode successor shall be 1->2, 2->0, 0->1, and 3->1 for the illegal encoding.
REQ-016 FSM states shall be IDLE, PRESS, WAIT_IDLE, REQ, RELEASE; a single 8-bit counter is shared by PRESS, REQ and RELEASE and is cleared on each state entry.
REQ-017 IDLE: btn_s=1 -> PRESS.
REQ-018 PRESS: btn_s=0 -> IDLE; otherwise the counter increments, and on the cycle it equals DEBOUNCE_CYCLES-1 -> WAIT_IDLE.
REQ-019 WAIT_IDLE: busy=0 -> REQ, with pending_mode <= successor(mode) on the same edge; busy=1 holds the state indefinitely; btn_s is ignored.
REQ-020 REQ: mode_req=1 for the whole state; busy is ignored.
REQ-021 REQ with ack=1: mode <= pending_mode on that edge, mode_stb=1 the following cycle only, then -> RELEASE.
REQ-022 REQ with ack=0: the counter increments; on the cycle it equals TIMEOUT_CYCLES-1 the block sets err, leaves mode unchanged, asserts no mode_stb, and -> RELEASE.
REQ-023 If ack=1 arrives on the timeout cycle, ack wins: commit, no err.
REQ-024 RELEASE: btn_s=1 clears the counter; otherwise the counter increments, and on the cycle it equals DEBOUNCE_CYCLES-1 -> IDLE. One press therefore yields at most one mode change.
REQ-025 ack outside REQ shall have no effect.
REQ-026 err_clr=1 clears err; a simultaneous err set wins.
REQ-027 Minimum latency shall be DEBOUNCE_CYCLES+2 clk from btn_s rising (busy=0) to mode_req rising, and 1 clk from ack-sampled edge to mode update.

Reset
REQ-028 nrst low shall asynchronously force:
  - state IDLE, counter 0, synchronizer flops 0;
  - mode=2'd1, pending_mode=2'd2;
  - mode_req=0, mode_stb=0, err=0.
REQ-029 Reset mid-operation shall abandon any pending request with no mode change; after release the block resumes from IDLE.

Structure
REQ-030 Package t09_mode_pkg shall hold:
  - mode constants MODE_0=2'd0, MODE_1=2'd1, MODE_2=2'd2;
  - the FSM state enum;
  - the mode-successor function.
REQ-031 The synchronizer shall be a sub-module named t09_btn_sync; the FSM, counter and output registers stay in t09_mode_ctrl.

Verification
REQ-032 The bench shall use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=8, and cover:
  - Reset: nrst low -> mode=1, pending_mode=2, mode_req=0, err=0.
  - Clean press, busy=0, ack 2 cycles after mode_req rises -> mode 1->2, one mode_stb pulse; further presses give 2->0, then 0->1.
  - Bounce: btn_s high 3 cycles, low, high 3 cycles -> never leaves IDLE/PRESS, mode_req stays 0.
  - Held button: btn high for 100 cycles with ack given -> exactly one mode change; a second change needs release for 4 or more cycles.
  - busy=1 for 20 cycles after debounce -> mode_req stays 0 until busy falls, then rises with pending_mode=successor.
  - No ack -> mode_req high 8 cycles then falls, err=1, mode unchanged; err_clr pulse -> err=0; ack on the 8th cycle -> commit, err stays 0.
